// File: rtl/tx_jesd_pkg.sv
// Shared constants and state encoding for the JESD204B TX link-startup sequencer.
package tx_jesd_pkg;

    localparam logic [7:0] K_K28_5 = 8'hBC;
    localparam logic [7:0] K_R     = 8'h1C;
    localparam logic [7:0] K_A     = 8'h7C;
    localparam logic [7:0] K_Q     = 8'h9C;

    localparam int unsigned ILAS_MF    = 4;
    localparam int unsigned CFG_OCTETS = 14;

    typedef enum logic [1:0] {
        StCgs  = 2'd0,
        StIlas = 2'd1,
        StData = 2'd2
    } state_t;

endpackage

// File: rtl/tx_ilas_seq_if.sv
// Octet streams around the sequencer: user octets in from transport, link octets out.
interface tx_ilas_seq_if;

    logic [7:0] i_data;
    logic       i_vld;
    logic       o_rdy;
    logic [7:0] o_data;
    logic       o_vld;
    logic       o_k;

    modport master (
        input  i_data,
        input  i_vld,
        output o_rdy,
        output o_data,
        output o_vld,
        output o_k
    );

    modport slave (
        output i_data,
        output i_vld,
        input  o_rdy,
        input  o_data,
        input  o_vld,
        input  o_k
    );

endinterface

// File: rtl/tx_lmfc_cnt.sv
// Local multiframe counter with SYSREF rising-edge re-phasing and a registered LMFC pulse.
module tx_lmfc_cnt #(
    parameter int unsigned MF_LEN = 32,
    parameter int unsigned CW     = $clog2(MF_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_sysref,
    output logic [CW-1:0] o_cnt,
    output logic          o_lmfc
);

    localparam logic [CW-1:0] LAST = CW'(MF_LEN - 1);

    logic          sysref_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          lmfc_q;

    // The SYSREF edge cycle itself counts as phase 0, so the counter resumes at 1.
    always_comb begin
        if (i_sysref && !sysref_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sysref_q <= 1'b0;
            cnt_q    <= '0;
            lmfc_q   <= 1'b0;
        end else begin
            sysref_q <= i_sysref;
            cnt_q    <= cnt_d;
            lmfc_q   <= (cnt_d == '0);
        end
    end

    assign o_cnt  = cnt_q;
    assign o_lmfc = lmfc_q;

endmodule

// File: rtl/tx_ilas_seq.sv
// JESD204B TX link-startup sequencer: CGS, four-multiframe ILAS, then user data pass-through.
module tx_ilas_seq
    import tx_jesd_pkg::*;
#(
    parameter int unsigned MF_LEN       = 32,
    parameter int unsigned SYNC_REQ_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_sync_n,
    input  logic                    i_sysref,
    input  logic [8*CFG_OCTETS-1:0] i_cfg,
    tx_ilas_seq_if.master           bus,
    output logic [1:0]              o_state,
    output logic                    o_lmfc
);

    localparam int unsigned CW = $clog2(MF_LEN);
    localparam int unsigned LW = $clog2(SYNC_REQ_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(MF_LEN - 1);

    if (MF_LEN < 17 || MF_LEN > 256) begin : g_bad_mf_len
        $error("tx_ilas_seq: MF_LEN must lie in 17..256");
    end

    state_t        state_q;
    logic [1:0]    mf_q;
    logic [CW-1:0] oct_q;
    logic [LW-1:0] low_q;
    logic [7:0]    data_q;
    logic          vld_q;
    logic          k_q;
    logic          rdy_q;

    logic [CW-1:0] lmfc_cnt;
    logic [7:0]    ilas_data;
    logic          ilas_k;
    logic [3:0]    cfg_idx;
    logic          resync;
    logic          ilas_last;

    tx_lmfc_cnt #(
        .MF_LEN (MF_LEN),
        .CW     (CW)
    ) u_lmfc (
        .clk      (clk),
        .rst      (rst),
        .i_sysref (i_sysref),
        .o_cnt    (lmfc_cnt),
        .o_lmfc   (o_lmfc)
    );

    // ilas_cnt is kept split as {multiframe, octet} so no divider is needed.
    assign cfg_idx   = 4'(oct_q - CW'(2));
    assign resync    = (state_q != StCgs) && (low_q == LW'(SYNC_REQ_LEN));
    assign ilas_last = (mf_q == 2'(ILAS_MF - 1)) && (oct_q == LAST);

    always_comb begin
        ilas_k    = 1'b0;
        ilas_data = 8'(oct_q);
        if (oct_q == '0) begin
            ilas_data = K_R;
            ilas_k    = 1'b1;
        end else if (oct_q == LAST) begin
            ilas_data = K_A;
            ilas_k    = 1'b1;
        end else if (mf_q == 2'd1 && oct_q == CW'(1)) begin
            ilas_data = K_Q;
            ilas_k    = 1'b1;
        end else if (mf_q == 2'd1 && oct_q >= CW'(2) && oct_q <= CW'(15)) begin
            ilas_data = 8'(i_cfg >> {cfg_idx, 3'b000});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StCgs;
            mf_q    <= '0;
            oct_q   <= '0;
            low_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            k_q     <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StCgs: begin
                    data_q <= K_K28_5;
                    k_q    <= 1'b1;
                    vld_q  <= 1'b1;
                    low_q  <= '0;
                    if (i_sync_n && lmfc_cnt == LAST) begin
                        state_q <= StIlas;
                    end
                end
                StIlas: begin
                    data_q <= ilas_data;
                    k_q    <= ilas_k;
                    vld_q  <= 1'b1;
                    if (oct_q == LAST) begin
                        oct_q <= '0;
                        mf_q  <= mf_q + 2'd1;
                    end else begin
                        oct_q <= oct_q + CW'(1);
                    end
                    if (ilas_last) begin
                        state_q <= StData;
                        rdy_q   <= 1'b1;
                    end
                end
                StData: begin
                    k_q   <= 1'b0;
                    vld_q <= bus.i_vld && rdy_q;
                    if (bus.i_vld && rdy_q) begin
                        data_q <= bus.i_data;
                    end
                end
                default: state_q <= StCgs;
            endcase

            if (state_q != StCgs) begin
                low_q <= i_sync_n ? '0 : low_q + LW'(1);
            end

            // A sustained SYNC~ request overrides any ILAS progress made this cycle.
            if (resync) begin
                state_q <= StCgs;
                rdy_q   <= 1'b0;
                low_q   <= '0;
                mf_q    <= '0;
                oct_q   <= '0;
            end
        end
    end

    assign bus.o_data = data_q;
    assign bus.o_vld  = vld_q;
    assign bus.o_k    = k_q;
    assign bus.o_rdy  = rdy_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_tx_ilas_seq.sv
// Directed bench for tx_ilas_seq: cycle model of the link-startup rules plus literal spot checks.
module tb_tx_ilas_seq;

    localparam int MF_LEN = 32;
    localparam int SRL    = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         sync_n;
    logic         sysref;
    logic [111:0] cfg;
    logic [1:0]   o_state;
    logic         o_lmfc;

    tx_ilas_seq_if u_if ();

    tx_ilas_seq #(
        .MF_LEN       (MF_LEN),
        .SYNC_REQ_LEN (SRL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_sync_n (sync_n),
        .i_sysref (sysref),
        .i_cfg    (cfg),
        .bus      (u_if),
        .o_state  (o_state),
        .o_lmfc   (o_lmfc)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: plain integers following the phase rules directly.
    int   m_state = 0;
    int   m_lmfc  = 0;
    int   m_ilas  = 0;
    int   m_low   = 0;
    bit   m_sref  = 0;
    bit   model_valid = 0;
    logic [7:0] e_data = '0;
    bit   e_vld = 0, e_k = 0, e_rdy = 0, e_lmfc = 0;
    int   e_state = 0;

    task automatic model_step();
        int nstate, p, mm;
        model_valid = 1;
        if (rst) begin
            m_state = 0; m_lmfc = 0; m_ilas = 0; m_low = 0; m_sref = 0;
            e_data = '0; e_vld = 0; e_k = 0; e_rdy = 0; e_lmfc = 0; e_state = 0;
            return;
        end
        case (m_state)
            0: begin e_data = 8'hBC; e_k = 1; e_vld = 1; end
            1: begin
                p  = m_ilas % MF_LEN;
                mm = m_ilas / MF_LEN;
                e_vld = 1;
                if (p == 0)                              begin e_data = 8'h1C; e_k = 1; end
                else if (p == MF_LEN - 1)                begin e_data = 8'h7C; e_k = 1; end
                else if (mm == 1 && p == 1)              begin e_data = 8'h9C; e_k = 1; end
                else if (mm == 1 && p >= 2 && p <= 15)   begin e_data = cfg[(p-2)*8 +: 8]; e_k = 0; end
                else                                     begin e_data = 8'(p); e_k = 0; end
            end
            default: begin
                e_k = 0;
                e_vld = u_if.i_vld;
                if (u_if.i_vld) e_data = u_if.i_data;
            end
        endcase
        nstate = m_state;
        if (m_state == 0) begin
            if (sync_n && m_lmfc == MF_LEN - 1) nstate = 1;
        end else if (m_low == SRL) begin
            nstate = 0;
        end else if (m_state == 1 && m_ilas == 4 * MF_LEN - 1) begin
            nstate = 2;
        end
        if (m_state != 0) m_low = sync_n ? 0 : m_low + 1;
        if (nstate == 0) m_low = 0;
        m_ilas = (m_state == 1 && nstate == 1) ? m_ilas + 1 : 0;
        if (sysref && !m_sref) m_lmfc = 1;
        else m_lmfc = (m_lmfc + 1) % MF_LEN;
        m_sref  = sysref;
        m_state = nstate;
        e_lmfc  = (m_lmfc == 0);
        e_rdy   = (nstate == 2);
        e_state = nstate;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            chk("cyc_data", u_if.o_data, e_data);
            chk("cyc_vld", u_if.o_vld, e_vld);
            chk("cyc_k", u_if.o_k, e_k);
            chk("cyc_rdy", u_if.o_rdy, e_rdy);
            chk("cyc_state", o_state, e_state);
            chk("cyc_lmfc", o_lmfc, e_lmfc);
        end
    end

    logic [7:0] rec_d [128];
    logic       rec_k [128];
    bit         found;
    bit         lm_prev;
    int         n;
    logic [7:0] last_d;
    bit         pat_v [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    logic [7:0] pat_d [8] = '{8'hA5, 8'h00, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'hA5, 8'h00};

    task automatic wait_lmfc(input int val);
        bit ok = 0;
        for (int i = 0; i < 4 * MF_LEN && !ok; i++) begin
            @(negedge clk);
            if (m_lmfc == val) ok = 1;
        end
        chk("wait_lmfc_phase", ok, 1);
    endtask

    initial begin
        rst = 1; sync_n = 0; sysref = 0;
        u_if.i_data = '0; u_if.i_vld = 0;
        for (int i = 0; i < 14; i++) cfg[i*8 +: 8] = 8'(i + 1);

        // Test 1: reset state, then steady CGS.
        repeat (3) @(negedge clk);
        chk("rst_data", u_if.o_data, 0);
        chk("rst_vld", u_if.o_vld, 0);
        chk("rst_k", u_if.o_k, 0);
        rst = 0;
        repeat (2) @(negedge clk);
        chk("cgs_data", u_if.o_data, 8'hBC);
        chk("cgs_k", u_if.o_k, 1);
        chk("cgs_vld", u_if.o_vld, 1);
        chk("cgs_rdy", u_if.o_rdy, 0);

        // Test 2: SYNC~ released at LMFC phase 10; /R/ arrives 23 cycles later.
        wait_lmfc(10);
        sync_n = 1;
        found = 0; n = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            n++;
            if (u_if.o_data == 8'h1C && u_if.o_k) found = 1;
        end
        chk("ilas_start_found", found, 1);
        chk("ilas_start_latency", n, 23);

        // Test 3: record all 128 ILAS octets; a SYSREF edge mid-ILAS must not disturb them.
        rec_d[0] = u_if.o_data; rec_k[0] = u_if.o_k;
        for (int i = 1; i < 128; i++) begin
            @(negedge clk);
            rec_d[i] = u_if.o_data; rec_k[i] = u_if.o_k;
            if (i == 50) sysref = 1;
            if (i == 53) sysref = 0;
        end
        chk("ilas_mf0_o1", rec_d[1], 8'h01);
        chk("ilas_mf0_o30", rec_d[30], 8'h1E);
        chk("ilas_mf0_o31", {rec_k[31], rec_d[31]}, 9'h17C);
        chk("ilas_mf1_o0", {rec_k[32], rec_d[32]}, 9'h11C);
        chk("ilas_mf1_q", {rec_k[33], rec_d[33]}, 9'h19C);
        chk("ilas_mf1_cfg0", {rec_k[34], rec_d[34]}, 9'h001);
        chk("ilas_mf1_cfg13", {rec_k[47], rec_d[47]}, 9'h00E);
        chk("ilas_mf1_o16", rec_d[48], 8'h10);
        chk("ilas_mf3_o0", {rec_k[96], rec_d[96]}, 9'h11C);
        chk("ilas_mf3_o31", {rec_k[127], rec_d[127]}, 9'h17C);
        chk("ilas_then_data", o_state, 2);

        // Test 4: DATA pass-through with toggling valid; idle cycles hold the last octet.
        last_d = 8'h7C;
        for (int i = 0; i < 8; i++) begin
            u_if.i_vld = pat_v[i];
            u_if.i_data = pat_d[i];
            @(negedge clk);
            if (pat_v[i]) last_d = pat_d[i];
            chk("data_vld", u_if.o_vld, pat_v[i]);
            chk("data_octet", u_if.o_data, last_d);
        end
        u_if.i_vld = 0;

        // Test 5: a 4-cycle SYNC~ pulse is ignored; 5 cycles force CGS.
        sync_n = 0;
        repeat (4) @(negedge clk);
        sync_n = 1;
        repeat (3) @(negedge clk);
        chk("short_sync_state", o_state, 2);
        chk("short_sync_rdy", u_if.o_rdy, 1);
        sync_n = 0;
        found = 0; n = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            n++;
            if (!u_if.o_rdy) found = 1;
        end
        chk("resync_rdy_drop", n, 6);
        @(negedge clk);
        chk("resync_cgs_data", {u_if.o_k, u_if.o_data}, 9'h1BC);
        sync_n = 1;
        found = 0; lm_prev = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            lm_prev = o_lmfc;
            @(negedge clk);
            if (u_if.o_data == 8'h1C && u_if.o_k) found = 1;
        end
        chk("reilas_found", found, 1);
        chk("reilas_on_lmfc", lm_prev, 1);

        // Test 6a: reset in the middle of ILAS.
        repeat (40) @(negedge clk);
        chk("mid_ilas_state", o_state, 1);
        rst = 1;
        @(negedge clk);
        chk("midrst_data", u_if.o_data, 0);
        chk("midrst_flags", {u_if.o_vld, u_if.o_k, u_if.o_rdy, o_lmfc}, 0);
        chk("midrst_state", o_state, 0);
        rst = 0; sync_n = 0;

        // Test 6b: SYSREF edge at phase 20 in CGS; next LMFC pulse is a full multiframe away.
        repeat (5) @(negedge clk);
        wait_lmfc(20);
        sysref = 1;
        found = 0; n = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            n++;
            if (o_lmfc) found = 1;
        end
        chk("sysref_lmfc_delay", n, MF_LEN);
        sysref = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
